// File: rtl/dm_port_arbiter.sv
// Two-requester front end for the single-port, word-write-only data memory.
// Requester 0 is the pipeline MEM stage, requester 1 is the debug/program loader.
// Loads and full-word stores finish in one cycle. Partial stores take two cycles:
// read the word, merge the enabled byte lanes, then write it back.
//
// Handshake: r*_req is a request that is held, with all fields stable, until
// the matching r*_gnt pulse. r*_gnt marks the cycle in which the access takes
// effect at the memory. For loads, r*_rvalid pulses one cycle after r*_gnt with
// the word on r*_rd. r*_rd then holds that value until the next load completes.
module dm_port_arbiter #(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int P0_PRIO = 0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            r0_req,
  input  logic            r0_we,
  input  logic [AW-1:0]   r0_addr,
  input  logic [DW/8-1:0] r0_be,
  input  logic [DW-1:0]   r0_wd,
  output logic            r0_gnt,
  output logic            r0_rvalid,
  output logic [DW-1:0]   r0_rd,
  input  logic            r1_req,
  input  logic            r1_we,
  input  logic [AW-1:0]   r1_addr,
  input  logic [DW/8-1:0] r1_be,
  input  logic [DW-1:0]   r1_wd,
  output logic            r1_gnt,
  output logic            r1_rvalid,
  output logic [DW-1:0]   r1_rd,
  output logic [AW-1:0]   dm_A,
  output logic [DW-1:0]   dm_WD,
  output logic            dm_We,
  input  logic [DW-1:0]   dm_RD,
  output logic            dbg_state
);

  localparam int BW = DW / 8;

  typedef enum logic {IDLE = 1'b0, RMW = 1'b1} state_t;

  state_t          state, state_d;
  logic            rr_ptr;
  logic            owner;
  logic [AW-1:0]   rmw_addr;
  logic [DW-1:0]   merged, merged_d;

  logic            any_req;
  logic            win;
  logic            w_we;
  logic [AW-1:0]   w_addr;
  logic [BW-1:0]   w_be;
  logic [DW-1:0]   w_wd;
  logic [1:0]      gnt;
  logic            load_gnt;
  logic            capture;

  // Pick the winner among asserted requests and mux its fields.
  always_comb begin
    any_req = r0_req | r1_req;
    if (r0_req && r1_req) win = (P0_PRIO != 0) ? 1'b0 : rr_ptr;
    else                  win = r1_req & ~r0_req;
    w_we   = win ? r1_we   : r0_we;
    w_addr = win ? r1_addr : r0_addr;
    w_be   = win ? r1_be   : r0_be;
    w_wd   = win ? r1_wd   : r0_wd;
  end

  // Next state, memory drive and grants. While Reset is high nothing is issued,
  // so a reset landing on the RMW write cycle drops that write and its grant.
  always_comb begin
    state_d  = state;
    dm_A     = '0;
    dm_WD    = '0;
    dm_We    = 1'b0;
    gnt      = 2'b00;
    load_gnt = 1'b0;
    capture  = 1'b0;
    merged_d = dm_RD;
    for (int i = 0; i < BW; i++) begin
      if (w_be[i]) merged_d[8*i +: 8] = w_wd[8*i +: 8];
    end
    if (!Reset) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            dm_A = w_addr;
            if (!w_we) begin
              gnt[win] = 1'b1;
              load_gnt = 1'b1;
            end else if (&w_be) begin
              dm_WD    = w_wd;
              dm_We    = 1'b1;
              gnt[win] = 1'b1;
            end else if (w_be == '0) begin
              gnt[win] = 1'b1;
            end else begin
              capture = 1'b1;
              state_d = RMW;
            end
          end
        end
        RMW: begin
          dm_A       = rmw_addr;
          dm_WD      = merged;
          dm_We      = 1'b1;
          gnt[owner] = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, round-robin pointer and the latched read-modify-write context.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      owner    <= 1'b0;
      rmw_addr <= '0;
      merged   <= '0;
    end else begin
      state <= state_d;
      if (|gnt) rr_ptr <= ~gnt[1];
      if (capture) begin
        owner    <= win;
        rmw_addr <= w_addr;
        merged   <= merged_d;
      end
    end
  end

  // Load return path: capture the memory word on the load grant cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rd     <= '0;
      r1_rd     <= '0;
    end else begin
      r0_rvalid <= load_gnt & gnt[0];
      r1_rvalid <= load_gnt & gnt[1];
      if (load_gnt && gnt[0]) r0_rd <= dm_RD;
      if (load_gnt && gnt[1]) r1_rd <= dm_RD;
    end
  end

  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];
  assign dbg_state = (state == RMW);

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: a round-robin instance backed by a memory
// model, plus a fixed-priority instance used for the grant-order case.
module tb_dm_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  // Clock / reset
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  // Round-robin instance signals
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [3:0]    r0_be, r1_be;
  logic [DW-1:0] r0_wd, r1_wd;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DW-1:0] r0_rd, r1_rd;
  logic [AW-1:0] dm_A;
  logic [DW-1:0] dm_WD, dm_RD;
  logic          dm_We, dbg_state;

  // Fixed-priority instance signals
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rd, p1_rd, p_WD;
  logic [AW-1:0] p_A;
  logic          p_We, p_state;

  // Memory model: combinational read, write at posedge
  logic [DW-1:0] mem [2**AW];
  logic          mem_clr;
  assign dm_RD = mem[dm_A];
  always @(posedge Clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (dm_We) begin
      mem[dm_A] <= dm_WD;
    end
  end

  dm_port_arbiter #(.AW(AW), .DW(DW), .P0_PRIO(0)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_be(r0_be), .r0_wd(r0_wd),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rd(r0_rd),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_be(r1_be), .r1_wd(r1_wd),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rd(r1_rd),
    .dm_A(dm_A), .dm_WD(dm_WD), .dm_We(dm_We), .dm_RD(dm_RD), .dbg_state(dbg_state)
  );

  dm_port_arbiter #(.AW(AW), .DW(DW), .P0_PRIO(1)) u_prio (
    .Clk(Clk), .Reset(Reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_be(r0_be), .r0_wd(r0_wd),
    .r0_gnt(p0_gnt), .r0_rvalid(p0_rvalid), .r0_rd(p0_rd),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_be(r1_be), .r1_wd(r1_wd),
    .r1_gnt(p1_gnt), .r1_rvalid(p1_rvalid), .r1_rd(p1_rd),
    .dm_A(p_A), .dm_WD(p_WD), .dm_We(p_We), .dm_RD(32'h0), .dbg_state(p_state)
  );

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_be = 4'h0; r0_wd = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_be = 4'h0; r1_wd = '0;
  endtask

  initial begin
    idle_inputs();
    Reset   = 1'b1;
    mem_clr = 1'b1;
    tick();
    tick();
    mem_clr = 1'b0;
    // Reset state, checked while reset is held
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_we", 32'(dm_We), 32'd0);
    chk("rst_rvalid0", 32'(r0_rvalid), 32'd0);
    chk("rst_rd0", r0_rd, 32'h0);
    chk("rst_gnt1", 32'(r1_gnt), 32'd0);
    Reset = 1'b0;
    #1;
    chk("idle_A", 32'(dm_A), 32'd0);
    chk("idle_WD", dm_WD, 32'h0);

    // 1: full store then load on r0
    tick();
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'd5; r0_wd = 32'hDEADBEEF; r0_be = 4'hF;
    #1;
    chk("t1_st_gnt", 32'(r0_gnt), 32'd1);
    chk("t1_st_we", 32'(dm_We), 32'd1);
    chk("t1_st_A", 32'(dm_A), 32'd5);
    chk("t1_st_WD", dm_WD, 32'hDEADBEEF);
    tick();
    r0_we = 1'b0;
    #1;
    chk("t1_ld_gnt", 32'(r0_gnt), 32'd1);
    chk("t1_ld_we", 32'(dm_We), 32'd0);
    chk("t1_ld_rv_early", 32'(r0_rvalid), 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("t1_rvalid", 32'(r0_rvalid), 32'd1);
    chk("t1_rd", r0_rd, 32'hDEADBEEF);
    tick();
    chk("t1_rvalid_pulse", 32'(r0_rvalid), 32'd0);
    chk("t1_rd_hold", r0_rd, 32'hDEADBEEF);

    // 2: r1 partial store into word 5
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 10'd5; r1_be = 4'b0010; r1_wd = 32'h0000AA00;
    #1;
    chk("t2_c1_gnt", 32'(r1_gnt), 32'd0);
    chk("t2_c1_we", 32'(dm_We), 32'd0);
    tick();
    chk("t2_c2_state", 32'(dbg_state), 32'd1);
    chk("t2_c2_gnt", 32'(r1_gnt), 32'd1);
    chk("t2_c2_we", 32'(dm_We), 32'd1);
    chk("t2_c2_WD", dm_WD, 32'hDEADAAEF);
    chk("t2_c2_A", 32'(dm_A), 32'd5);
    tick();
    r1_we = 1'b0;
    #1;
    chk("t2_ld_gnt", 32'(r1_gnt), 32'd1);
    tick();
    idle_inputs();
    #1;
    chk("t2_rvalid", 32'(r1_rvalid), 32'd1);
    chk("t2_rd", r1_rd, 32'hDEADAAEF);

    // 3: both loads held four cycles; round-robin vs fixed priority
    tick();
    r0_req = 1'b1; r0_addr = 10'd5;
    r1_req = 1'b1; r1_addr = 10'd7;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t3_rr_gnt0_%0d", i), 32'(r0_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_rr_gnt1_%0d", i), 32'(r1_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("t3_pr_gnt0_%0d", i), 32'(p0_gnt), 32'd1);
      chk($sformatf("t3_pr_gnt1_%0d", i), 32'(p1_gnt), 32'd0);
      tick();
    end
    idle_inputs();

    // 4: r0 partial store while r1 load pending
    tick();
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'd9; r0_be = 4'b0001; r0_wd = 32'h00000055;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'd5;
    #1;
    chk("t4_c1_gnt0", 32'(r0_gnt), 32'd0);
    chk("t4_c1_gnt1", 32'(r1_gnt), 32'd0);
    tick();
    chk("t4_c2_gnt0", 32'(r0_gnt), 32'd1);
    chk("t4_c2_gnt1", 32'(r1_gnt), 32'd0);
    chk("t4_c2_WD", dm_WD, 32'h00000055);
    tick();
    r0_req = 1'b0;
    #1;
    chk("t4_c3_gnt1", 32'(r1_gnt), 32'd1);
    chk("t4_c3_A", 32'(dm_A), 32'd5);
    chk("t4_mem9", mem[9], 32'h00000055);
    tick();
    idle_inputs();
    #1;
    chk("t4_rd1", r1_rd, 32'hDEADAAEF);

    // 5: reset asserted during the RMW write cycle
    tick();
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'd5; r0_be = 4'b1000; r0_wd = 32'h11000000;
    tick();
    Reset = 1'b1;
    #1;
    chk("t5_we", 32'(dm_We), 32'd0);
    chk("t5_gnt", 32'(r0_gnt), 32'd0);
    tick();
    Reset = 1'b0;
    idle_inputs();
    #1;
    chk("t5_state", 32'(dbg_state), 32'd0);
    chk("t5_rvalid1", 32'(r1_rvalid), 32'd0);
    chk("t5_rd0", r0_rd, 32'h0);
    chk("t5_rd1", r1_rd, 32'h0);
    chk("t5_mem5", mem[5], 32'hDEADAAEF);

    // 6: zero byte-enable store is a one-cycle no-op
    tick();
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 10'd5; r1_be = 4'b0000; r1_wd = 32'hFFFFFFFF;
    #1;
    chk("t6_gnt", 32'(r1_gnt), 32'd1);
    chk("t6_we", 32'(dm_We), 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("t6_we_after", 32'(dm_We), 32'd0);
    chk("t6_mem5", mem[5], 32'hDEADAAEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
